// File: rtl/uart_frame_scheduler_pkg.sv
// Shared types and the pixel scaling helper for the UART frame scheduler.
package uart_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_MSG    = 3'd1,
      ST_HEADER = 3'd2,
      ST_FETCH  = 3'd3,
      ST_WAIT   = 3'd4,
      ST_SEND   = 3'd5
   } state_t;

   typedef enum logic {
      GRANT_FRAME = 1'b0,
      GRANT_MSG   = 1'b1
   } grant_t;

   localparam logic [7:0] DEFAULT_HEADER_BYTE = 8'h00;

   // Round-to-nearest divide by 16 with saturation, or plain truncation.
   function automatic logic [7:0] scale_pixel(input logic [11:0] d, input logic trunc);
      logic [12:0] r;
      r = 13'(d) + 13'd8;
      if (trunc)      return d[11:4];
      else if (r[12]) return 8'hFF;
      else            return r[11:4];
   endfunction

endpackage

// File: rtl/uart_frame_scheduler_if.sv
// BRAM read port, status-message queue and UART byte channel of the scheduler.
interface uart_frame_scheduler_if #(parameter int unsigned AW = 8);

   logic [AW-1:0] read_addr;
   logic [11:0]   data_in;
   logic          msg_valid;
   logic [7:0]    msg_byte;
   logic          msg_ready;
   logic          tx_ready;
   logic          tx_valid;
   logic [7:0]    tx_data;

   modport master (
      output read_addr, msg_ready, tx_valid, tx_data,
      input  data_in, msg_valid, msg_byte, tx_ready
   );

   modport slave (
      input  read_addr, msg_ready, tx_valid, tx_data,
      output data_in, msg_valid, msg_byte, tx_ready
   );

endinterface

// File: rtl/uart_frame_scheduler.sv
// Streams header + scaled pixels of a BRAM frame to a UART byte channel and
// round-robin shares that channel with single status bytes between frames.
module uart_frame_scheduler
   import uart_sched_pkg::*;
#(
   parameter int unsigned SW_WIRE_CNT  = 16,
   parameter int unsigned RD_WIRE_CNT  = 16,
   parameter logic [7:0]  HEADER_BYTE  = DEFAULT_HEADER_BYTE,
   parameter int unsigned BRAM_LATENCY = 2
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   enable,
   input  logic                   truncate,
   input  logic                   frame_ready,
   uart_frame_scheduler_if.master bus,
   output logic                   busy,
   output logic                   frame_done,
   output logic                   frame_dropped
);

   localparam int unsigned N  = SW_WIRE_CNT * RD_WIRE_CNT;
   localparam int unsigned AW = $clog2(N);
   localparam int unsigned LW = (BRAM_LATENCY > 1) ? $clog2(BRAM_LATENCY) : 1;

   logic [1:0] rst_sync_q;
   logic       rst;

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [LW-1:0] cnt_q, cnt_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          tx_valid_q, tx_valid_d;
   logic          msg_ready_q, msg_ready_d;
   logic          busy_q, busy_d;
   logic          frame_done_q, frame_done_d;
   logic          dropped_q, dropped_d;
   logic          pending_q, pending_d;
   grant_t        last_grant_q, last_grant_d;
   logic          xfer, hdr_xfer, cand_f, cand_m;

   // Reset asserts immediately, releases two clocks after rst_in falls.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) rst_sync_q <= 2'b11;
      else        rst_sync_q <= {rst_sync_q[0], 1'b0};
   end
   assign rst = rst_sync_q[1];

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         cnt_q        <= '0;
         tx_data_q    <= 8'h00;
         tx_valid_q   <= 1'b0;
         msg_ready_q  <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         dropped_q    <= 1'b0;
         pending_q    <= 1'b0;
         last_grant_q <= GRANT_MSG;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         cnt_q        <= cnt_d;
         tx_data_q    <= tx_data_d;
         tx_valid_q   <= tx_valid_d;
         msg_ready_q  <= msg_ready_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         dropped_q    <= dropped_d;
         pending_q    <= pending_d;
         last_grant_q <= last_grant_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      cnt_d        = cnt_q;
      tx_data_d    = tx_data_q;
      pending_d    = pending_q;
      last_grant_d = last_grant_q;
      msg_ready_d  = 1'b0;
      frame_done_d = 1'b0;
      dropped_d    = 1'b0;
      xfer         = tx_valid_q && bus.tx_ready;
      hdr_xfer     = xfer && (state_q == ST_HEADER);
      cand_f       = enable && pending_q;
      cand_m       = bus.msg_valid;

      case (state_q)
         ST_IDLE: begin
            if (cand_f && (!cand_m || last_grant_q == GRANT_MSG)) begin
               state_d      = ST_HEADER;
               tx_data_d    = HEADER_BYTE;
               last_grant_d = GRANT_FRAME;
            end else if (cand_m) begin
               state_d      = ST_MSG;
               tx_data_d    = bus.msg_byte;
               msg_ready_d  = 1'b1;
               last_grant_d = GRANT_MSG;
            end
         end
         ST_MSG: if (xfer) state_d = ST_IDLE;
         ST_HEADER: begin
            if (xfer) begin
               state_d = ST_FETCH;
               addr_d  = '0;
            end
         end
         ST_FETCH: begin
            state_d = ST_WAIT;
            cnt_d   = LW'(BRAM_LATENCY - 1);
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               tx_data_d = scale_pixel(bus.data_in, truncate);
               state_d   = ST_SEND;
            end else begin
               cnt_d = cnt_q - LW'(1);
            end
         end
         ST_SEND: begin
            if (xfer) begin
               if (addr_q == AW'(N - 1)) begin
                  addr_d       = '0;
                  frame_done_d = 1'b1;
                  state_d      = ST_IDLE;
               end else begin
                  addr_d  = addr_q + AW'(1);
                  state_d = ST_FETCH;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A frame_ready coinciding with the header transfer queues the next frame.
      if (frame_ready) begin
         dropped_d = pending_q && !hdr_xfer;
         pending_d = 1'b1;
      end else if (hdr_xfer) begin
         pending_d = 1'b0;
      end

      tx_valid_d = (state_d == ST_MSG) || (state_d == ST_HEADER) || (state_d == ST_SEND);
      busy_d     = (state_d != ST_IDLE);
   end

   assign bus.read_addr = addr_q;
   assign bus.tx_data   = tx_data_q;
   assign bus.tx_valid  = tx_valid_q;
   assign bus.msg_ready = msg_ready_q;
   assign busy          = busy_q;
   assign frame_done    = frame_done_q;
   assign frame_dropped = dropped_q;

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Self-checking bench: byte-stream scoreboard from a frame/arbitration model.
module tb_uart_frame_scheduler;
   import uart_sched_pkg::*;

   localparam int unsigned SW = 16;
   localparam int unsigned RD = 16;
   localparam int unsigned N  = SW * RD;
   localparam int unsigned L  = 2;

   logic       clk_in = 1'b0, rst_in = 1'b1;
   logic       enable = 1'b0, truncate = 1'b0, frame_ready = 1'b0;
   logic       tx_ready = 1'b1, msg_valid = 1'b0;
   logic [7:0] msg_byte = 8'h00;
   logic       busy, frame_done, frame_dropped;

   logic [11:0] mem  [N];
   logic [11:0] pipe [L];
   int cyc = 0;
   int n_tests = 0, n_fail = 0;
   bit rand_ready = 1'b0;
   int exp_b [8192];
   int rx_b  [8192];
   int wr_idx = 0, rd_idx = 0;
   int done_cnt = 0, drop_cnt = 0, mr_cnt = 0, valid_cnt = 0;

   uart_frame_scheduler_if #(.AW(8)) bus();
   assign bus.tx_ready  = tx_ready;
   assign bus.msg_valid = msg_valid;
   assign bus.msg_byte  = msg_byte;
   assign bus.data_in   = pipe[L-1];

   uart_frame_scheduler #(
      .SW_WIRE_CNT(SW), .RD_WIRE_CNT(RD), .HEADER_BYTE(8'h00), .BRAM_LATENCY(L)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in), .enable(enable), .truncate(truncate),
      .frame_ready(frame_ready), .bus(bus), .busy(busy),
      .frame_done(frame_done), .frame_dropped(frame_dropped)
   );

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   // BRAM read port with L cycles of latency from address to data.
   always @(posedge clk_in) begin
      pipe[0] <= mem[bus.read_addr];
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
   end

   task automatic check(input string name, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic int model_scale(input int v, input bit t);
      int r;
      if (t) return v / 16;
      r = (v + 8) / 16;
      return (r > 255) ? 255 : r;
   endfunction

   task automatic push(input int b);
      exp_b[wr_idx] = b;
      wr_idx++;
   endtask

   task automatic push_frame();
      push(0);
      for (int a = 0; a < int'(N); a++) push(model_scale(int'(mem[a]), truncate));
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic pulse_fr();
      frame_ready = 1'b1;
      step(1);
      frame_ready = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int k = 0;
      while (rd_idx < wr_idx && k < budget) begin step(1); k++; end
      check(name, rd_idx, wr_idx);
   endtask

   task automatic wait_addr(input int a, input int budget);
      int k = 0;
      while (int'(bus.read_addr) != a && k < budget) begin step(1); k++; end
      check("reach_addr", int'(bus.read_addr), a);
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_tx_valid"}, bus.tx_valid, 0);
      check({pfx, "_tx_data"}, bus.tx_data, 0);
      check({pfx, "_read_addr"}, bus.read_addr, 0);
      check({pfx, "_msg_ready"}, bus.msg_ready, 0);
      check({pfx, "_busy"}, busy, 0);
      check({pfx, "_frame_done"}, frame_done, 0);
      check({pfx, "_frame_dropped"}, frame_dropped, 0);
   endtask

   task automatic apply_reset();
      rst_in = 1'b1;
      step(3);
      check_reset_outputs("reset");
      rst_in = 1'b0;
      step(4);
      wr_idx = rd_idx;
   endtask

   task automatic drive_ready();
      forever begin
         @(posedge clk_in);
         #1;
         tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   endtask

   // Compare process: every handshake against the scoreboard, plus hold rules.
   task automatic monitor();
      bit         pstall = 1'b0;
      logic [7:0] pdata  = 8'h00;
      forever begin
         @(negedge clk_in);
         if (rst_in) begin
            pstall = 1'b0;
         end else begin
            if (pstall) begin
               check("hold_valid", bus.tx_valid, 1);
               check("hold_data", bus.tx_data, pdata);
            end
            if (bus.tx_valid) begin
               valid_cnt++;
               check("busy_with_valid", busy, 1);
            end
            if (bus.tx_valid && tx_ready) begin
               if (rd_idx >= wr_idx) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_byte: actual %0d required none (cycle %0d)",
                           bus.tx_data, cyc);
               end else begin
                  check("tx_byte", bus.tx_data, exp_b[rd_idx]);
                  rx_b[rd_idx] = bus.tx_data;
                  rd_idx++;
               end
            end
            if (frame_done) begin
               done_cnt++;
               check("busy_at_done", busy, 0);
            end
            if (frame_dropped) drop_cnt++;
            if (bus.msg_ready) mr_cnt++;
            pstall = bus.tx_valid && !tx_ready;
            pdata  = bus.tx_data;
         end
      end
   endtask

   initial begin
      int t0, k, base, d0, m0, v0;
      fork
         monitor();
         drive_ready();
      join_none

      for (int a = 0; a < int'(N); a++) mem[a] = 12'(a * 16);
      apply_reset();

      // Ramp frame: exact stream, grant latency and frame length.
      enable = 1'b1;
      base = wr_idx;
      d0 = done_cnt;
      push_frame();
      t0 = cyc;
      pulse_fr();
      k = 0;
      do begin @(negedge clk_in); k++; end while (!bus.tx_valid && k < 20);
      check("grant_latency", cyc - t0, 2);
      k = 0;
      while (!frame_done && k < 3000) begin @(negedge clk_in); k++; end
      check("frame_done_cycle", cyc - t0, 1 + 2 + int'(N) * (L + 2));
      step(10);
      wait_drain("ramp_drain", 100);
      check("ramp_done_count", done_cnt - d0, 1);
      check("ramp_header", rx_b[base], 0);
      for (int a = 0; a < int'(N); a++) check("ramp_pixel", rx_b[base + 1 + a], a);

      // Scaling corner values, rounded then truncated.
      for (int t = 0; t < 2; t++) begin
         for (int a = 0; a < int'(N); a++) mem[a] = 12'($urandom_range(0, 4095));
         mem[0] = 12'd4095; mem[1] = 12'd4087; mem[2] = 12'd8; mem[3] = 12'd7;
         truncate = 1'(t);
         base = wr_idx;
         push_frame();
         pulse_fr();
         wait_drain("scale_drain", 3000);
         step(3);
         check("scale_4095", rx_b[base + 1], 255);
         check("scale_4087", rx_b[base + 2], 255);
         check("scale_8", rx_b[base + 3], (t == 0) ? 1 : 0);
         check("scale_7", rx_b[base + 4], 0);
      end

      // Randomly throttled transmitter, same ramp stream.
      for (int a = 0; a < int'(N); a++) mem[a] = 12'(a * 16);
      truncate = 1'($urandom_range(0, 1));
      rand_ready = 1'b1;
      push_frame();
      pulse_fr();
      wait_drain("stall_drain", 8000);
      rand_ready = 1'b0;
      step(3);

      // Frame and message requested together after reset: frame first.
      apply_reset();
      for (int a = 0; a < int'(N); a++) mem[a] = 12'($urandom_range(0, 4095));
      m0 = mr_cnt;
      push_frame();
      push(8'hA5);
      pulse_fr();
      msg_valid = 1'b1;
      msg_byte  = 8'hA5;
      k = 0;
      while (!bus.msg_ready && k < 3000) begin @(negedge clk_in); k++; end
      step(1);
      msg_valid = 1'b0;
      wait_drain("arb_drain", 100);
      step(5);
      check("msg_ready_pulses", mr_cnt - m0, 1);

      // Drops: second early pulse dropped, mid-frame pulse queues a second frame.
      enable = 1'b0;
      d0 = drop_cnt;
      v0 = done_cnt;
      pulse_fr();
      step(2);
      pulse_fr();
      step(3);
      check("drop_early", drop_cnt - d0, 1);
      base = wr_idx;
      push_frame();
      push_frame();
      enable = 1'b1;
      wait_addr(100, 600);
      enable = 1'b0;
      pulse_fr();
      k = 0;
      while (rd_idx < base + int'(N) + 1 && k < 3000) begin step(1); k++; end
      step(20);
      check("enable_low_holds", rd_idx, base + int'(N) + 1);
      enable = 1'b1;
      wait_drain("drop_drain", 3000);
      step(5);
      check("drop_total", drop_cnt - d0, 1);
      check("two_frames", done_cnt - v0, 2);

      // Reset in the middle of pixel 37 with another frame pending.
      push_frame();
      pulse_fr();
      wait_addr(37, 600);
      pulse_fr();
      #2;
      rst_in = 1'b1;
      #1;
      check_reset_outputs("async_reset");
      step(3);
      rst_in = 1'b0;
      step(4);
      wr_idx = rd_idx;
      v0 = valid_cnt;
      step(60);
      check("post_reset_quiet", valid_cnt - v0, 0);
      check("post_reset_busy", busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
